divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 32 +++
 rtl/Divider.sv | 36 +++
 rtl/Divider_Unsighed.sv | 36 +++
 rtl/divider.sv | 164 ++++++++++++++++
 tb/tb_divider.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// divider_pkg -- shared definitions for the iterative divider.
//   DIV_WIDTH   : operand width (quotient and remainder are each this wide)
//   DIV_ITER    : number of radix-2 iterations (one quotient bit each)
//   DIV_LATENCY : edges from operand capture to the result strobe
//   div_state_e : controller states IDLE -> CALC -> FIX -> DONE
//   cond_negate : two's-complement negation when 'neg' is set, used both
//                 for taking magnitudes and for applying the result signs
package divider_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] cond_negate(input logic [DIV_WIDTH-1:0] v,
                                                       input logic                 neg);
    logic [DIV_WIDTH-1:0] res;
    if (neg) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/Divider.sv
// Divider -- legacy name for the signed divider (divider with SIGNED=1).
//   Ports identical to divider; m_axis_dout_tuser exists only when
//   DIVIDER_DBZ_FLAG_EN is defined.
module Divider
  import divider_pkg::*;
(
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_divisor_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic                   s_axis_dividend_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
  output logic                   m_axis_dout_tvalid,
  output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic                   m_axis_dout_tuser
`endif
);

  divider #(.SIGNED(1'b1)) u_divider (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tdata      (m_axis_dout_tdata)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .m_axis_dout_tuser      (m_axis_dout_tuser)
`endif
  );

endmodule

// File: rtl/Divider_Unsighed.sv
// Divider_Unsighed -- legacy name for the unsigned divider (divider with SIGNED=0).
//   Ports identical to divider; m_axis_dout_tuser exists only when
//   DIVIDER_DBZ_FLAG_EN is defined.
module Divider_Unsighed
  import divider_pkg::*;
(
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_divisor_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic                   s_axis_dividend_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
  output logic                   m_axis_dout_tvalid,
  output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic                   m_axis_dout_tuser
`endif
);

  divider #(.SIGNED(1'b0)) u_divider (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tdata      (m_axis_dout_tdata)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .m_axis_dout_tuser      (m_axis_dout_tuser)
`endif
  );

endmodule

// File: rtl/divider.sv
// divider -- 32-bit iterative radix-2 restoring divider, fixed 34-cycle latency.
//   aclk / aresetn            : clock, asynchronous active-low reset
//   s_axis_divisor_tvalid/tdata  : divisor operand (no tready)
//   s_axis_dividend_tvalid/tdata : dividend operand (no tready)
//   m_axis_dout_tvalid        : one-cycle result strobe
//   m_axis_dout_tdata         : {quotient, remainder}, held until next result
//   m_axis_dout_tuser         : divide-by-zero flag, present only when the
//                               macro DIVIDER_DBZ_FLAG_EN is defined
// SIGNED=1 gives truncating two's-complement division (remainder takes the
// sign of the dividend); SIGNED=0 gives unsigned division. Divisor 0 yields
// quotient all-ones and remainder equal to the dividend in both modes.
module divider
  import divider_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_divisor_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic                   s_axis_dividend_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
  output logic                   m_axis_dout_tvalid,
  output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic                   m_axis_dout_tuser
`endif
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  div_state_e             state_r;
  div_state_e             state_nxt_s;
  logic [4:0]             cnt_r;
  logic [DIV_WIDTH-1:0]   quo_r;     // dividend magnitude shifting out, quotient bits shifting in
  logic [DIV_WIDTH-1:0]   rem_r;     // partial remainder
  logic [DIV_WIDTH-1:0]   dvs_r;     // divisor magnitude
  logic [DIV_WIDTH-1:0]   dvd_r;     // original dividend, returned on divide-by-zero
  logic                   neg_q_r;
  logic                   neg_rem_r;
  logic                   dbz_r;
  logic [2*DIV_WIDTH-1:0] res_r;     // sign-corrected result staged for DONE
`ifdef DIVIDER_DBZ_FLAG_EN
  logic                   res_dbz_r;
`endif

  logic                   accept_s;
  logic                   dvd_neg_s;
  logic                   dvs_neg_s;
  logic [DIV_WIDTH:0]     shift_s;
  logic                   fits_s;
  logic [DIV_WIDTH-1:0]   trial_s;

  // Operand acceptance, operand signs and the restoring trial subtraction.
  always_comb begin
    accept_s  = (state_r == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
    dvd_neg_s = SIGNED && s_axis_dividend_tdata[DIV_WIDTH-1];
    dvs_neg_s = SIGNED && s_axis_divisor_tdata[DIV_WIDTH-1];
    shift_s   = {rem_r, quo_r[DIV_WIDTH-1]};
    fits_s    = (shift_s >= {1'b0, dvs_r});
    // When the divisor fits, the true difference is below 2^32, so the
    // low-order subtraction is exact.
    trial_s   = shift_s[DIV_WIDTH-1:0] - dvs_r;
  end

  // Controller next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_ITER) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: capture, iterate, sign-correct, then publish the result.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r              <= 5'd0;
      quo_r              <= 32'd0;
      rem_r              <= 32'd0;
      dvs_r              <= 32'd0;
      dvd_r              <= 32'd0;
      neg_q_r            <= 1'b0;
      neg_rem_r          <= 1'b0;
      dbz_r              <= 1'b0;
      res_r              <= 64'd0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= 64'd0;
`ifdef DIVIDER_DBZ_FLAG_EN
      res_dbz_r          <= 1'b0;
      m_axis_dout_tuser  <= 1'b0;
`endif
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dvd_r     <= s_axis_dividend_tdata;
            quo_r     <= cond_negate(s_axis_dividend_tdata, dvd_neg_s);
            dvs_r     <= cond_negate(s_axis_divisor_tdata, dvs_neg_s);
            rem_r     <= 32'd0;
            cnt_r     <= 5'd0;
            neg_q_r   <= dvd_neg_s ^ dvs_neg_s;
            neg_rem_r <= dvd_neg_s;
            dbz_r     <= (s_axis_divisor_tdata == 32'd0);
          end
        end
        CALC: begin
          quo_r <= {quo_r[DIV_WIDTH-2:0], fits_s};
          rem_r <= fits_s ? trial_s : shift_s[DIV_WIDTH-1:0];
          cnt_r <= cnt_r + 5'd1;
        end
        FIX: begin
          // 0x80000000 / -1 needs no special case: the magnitude quotient
          // 0x80000000 with a positive sign already reads as 0x80000000.
          if (dbz_r) begin
            res_r <= {32'hFFFF_FFFF, dvd_r};
          end else begin
            res_r <= {cond_negate(quo_r, neg_q_r), cond_negate(rem_r, neg_rem_r)};
          end
`ifdef DIVIDER_DBZ_FLAG_EN
          res_dbz_r <= dbz_r;
`endif
        end
        DONE: begin
          m_axis_dout_tvalid <= 1'b1;
          m_axis_dout_tdata  <= res_r;
`ifdef DIVIDER_DBZ_FLAG_EN
          m_axis_dout_tuser  <= res_dbz_r;
`endif
        end
        default: begin
          m_axis_dout_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider -- self-checking bench for divider (signed and unsigned
// instances plus the signed legacy wrapper), compared against a plain
// arithmetic reference model. Exercises DIVIDER_DBZ_FLAG_EN when defined.
module tb_divider;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        div_tvalid = 1'b0;
  logic        dvd_tvalid = 1'b0;
  logic [31:0] div_tdata = 32'd0;
  logic [31:0] dvd_tdata = 32'd0;

  logic        s_tvalid, u_tvalid, l_tvalid;
  logic [63:0] s_tdata, u_tdata, l_tdata;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic        s_tuser, u_tuser, l_tuser;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  divider #(.SIGNED(1'b1)) u_dut_s (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_divisor_tvalid(div_tvalid), .s_axis_divisor_tdata(div_tdata),
    .s_axis_dividend_tvalid(dvd_tvalid), .s_axis_dividend_tdata(dvd_tdata),
    .m_axis_dout_tvalid(s_tvalid), .m_axis_dout_tdata(s_tdata)
`ifdef DIVIDER_DBZ_FLAG_EN
    , .m_axis_dout_tuser(s_tuser)
`endif
  );

  Divider_Unsighed u_dut_u (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_divisor_tvalid(div_tvalid), .s_axis_divisor_tdata(div_tdata),
    .s_axis_dividend_tvalid(dvd_tvalid), .s_axis_dividend_tdata(dvd_tdata),
    .m_axis_dout_tvalid(u_tvalid), .m_axis_dout_tdata(u_tdata)
`ifdef DIVIDER_DBZ_FLAG_EN
    , .m_axis_dout_tuser(u_tuser)
`endif
  );

  Divider u_dut_l (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_divisor_tvalid(div_tvalid), .s_axis_divisor_tdata(div_tdata),
    .s_axis_dividend_tvalid(dvd_tvalid), .s_axis_dividend_tdata(dvd_tdata),
    .m_axis_dout_tvalid(l_tvalid), .m_axis_dout_tdata(l_tdata)
`ifdef DIVIDER_DBZ_FLAG_EN
    , .m_axis_dout_tuser(l_tuser)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain SV arithmetic (signed / truncates toward zero, % takes
  // the dividend's sign) plus the divide-by-zero and overflow rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    int          sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Issue one operation; optionally try to inject a second one after sample
  // 'inject_at' of the busy period. Checks latency and all three results.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                        output logic [63:0] got_s, output logic [63:0] got_u);
    int n;
    bit seen;
    @(negedge aclk);
    dvd_tdata = a; div_tdata = b; dvd_tvalid = 1'b1; div_tvalid = 1'b1;
    @(posedge aclk); #1;
    check_eq("pulse_width", {63'd0, s_tvalid}, 64'd0);
    @(negedge aclk);
    dvd_tvalid = 1'b0; div_tvalid = 1'b0;
    dvd_tdata = $urandom; div_tdata = $urandom;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge aclk); #1;
      n++;
      if (s_tvalid) begin
        seen = 1'b1;
      end else if (n == inject_at) begin
        @(negedge aclk);
        dvd_tdata = 32'hFFFF_0000; div_tdata = 32'd3; dvd_tvalid = 1'b1; div_tvalid = 1'b1;
        @(negedge aclk);
        dvd_tvalid = 1'b0; div_tvalid = 1'b0;
        n++;
        if (s_tvalid) seen = 1'b1;
      end
    end
    check_eq("latency", 64'(n), 64'd34);
    check_eq("u_tvalid", {63'd0, u_tvalid}, 64'd1);
    check_eq("l_tvalid", {63'd0, l_tvalid}, 64'd1);
    check_eq("signed_data", s_tdata, ref_div(a, b, 1'b1));
    check_eq("unsigned_data", u_tdata, ref_div(a, b, 1'b0));
    check_eq("legacy_data", l_tdata, ref_div(a, b, 1'b1));
`ifdef DIVIDER_DBZ_FLAG_EN
    check_eq("s_tuser", {63'd0, s_tuser}, {63'd0, (b == 32'd0)});
    check_eq("u_tuser", {63'd0, u_tuser}, {63'd0, (b == 32'd0)});
`endif
    got_s = s_tdata;
    got_u = u_tdata;
  endtask

  // Count tvalid pulses over a window of cycles.
  task automatic watch(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge aclk); #1;
      if (s_tvalid || u_tvalid || l_tvalid) pulses++;
    end
  endtask

  initial begin
    logic [63:0] rs, ru, first_s;
    logic [31:0] a, b;
    int pulses;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_tvalid", {63'd0, s_tvalid | u_tvalid}, 64'd0);
    check_eq("rst_tdata", s_tdata | u_tdata, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_eq("post_rst_tdata", s_tdata, 64'd0);

    // Directed vectors
    run_op(32'd100, 32'd7, 0, rs, ru);
    check_eq("u_100_7", ru, 64'h0000000E_00000002);
    run_op(32'hFFFF_FFF9, 32'd2, 0, rs, ru);
    check_eq("s_m7_2", rs, 64'hFFFFFFFD_FFFFFFFF);
    run_op(32'd7, 32'hFFFF_FFFE, 0, rs, ru);
    check_eq("s_7_m2", rs, 64'hFFFFFFFD_00000001);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, rs, ru);
    check_eq("s_ovf", rs, 64'h80000000_00000000);
    run_op(32'd5, 32'd0, 0, rs, ru);
    check_eq("s_dbz", rs, 64'hFFFFFFFF_00000005);
    check_eq("u_dbz", ru, 64'hFFFFFFFF_00000005);

    // Randomized, back-to-back
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        default: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      endcase
      run_op(a, b, 0, rs, ru);
    end

    // Operation offered while busy is dropped
    run_op(32'd1000, 32'd7, 10, rs, ru);
    first_s = rs;
    watch(45, pulses);
    check_eq("drop_pulses", 64'(pulses), 64'd0);
    check_eq("hold_tdata", s_tdata, first_s);
    check_eq("drop_value", first_s, 64'h0000008E_00000006);

    // Reset mid-operation
    @(negedge aclk);
    dvd_tdata = 32'd12345; div_tdata = 32'd17; dvd_tvalid = 1'b1; div_tvalid = 1'b1;
    @(negedge aclk);
    dvd_tvalid = 1'b0; div_tvalid = 1'b0;
    repeat (19) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_eq("abort_tdata", s_tdata | u_tdata, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    watch(50, pulses);
    check_eq("abort_pulses", 64'(pulses), 64'd0);
    check_eq("abort_hold", s_tdata, 64'd0);
    run_op(32'd9, 32'd3, 0, rs, ru);
    check_eq("s_9_3", rs, 64'h00000003_00000000);
    check_eq("u_9_3", ru, 64'h00000003_00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
